sram_bank_seq: RTL and testbench
================================

Name: sram_bank_seq

Overview:
- Parametrised, synthesizable successor to the single 6T bit-cell model: a DATA_W x DEPTH SRAM bank with a built-in phase sequencer (precharge, wordline, sense/write).
- Replaces global write_en/sense_en hierarchical references with explicit per-bank strobe outputs.
- Sits between the DPE memory controller and the array.
- Accepts one request at a time through a valid/ready handshake and returns read data with fixed, parameter-determined latency.

Parameters:
- DATA_W, 8: word width in bits, ≥1.
- DEPTH, 64: number of words, ≥2; need not be a power of 2.
- ADDR_W, $clog2(DEPTH): derived, localparam, not overridable.
- PRE_CYCLES, 2: precharge phase length in cycles, ≥1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept a request (state IDLE).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- inj_perr  in  1  test only: store inverted parity on this write (used only with the optional feature).
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_rdata  out  DATA_W  read data; holds its value until the next response.
- rsp_perr  out  1  parity error flag, qualified by rsp_valid.
- pre_en  out  1  precharge phase strobe.
- wl_en  out  1  wordline active.
- wl_addr  out  ADDR_W  active row.
- sense_en  out  1  sense-amp phase strobe.
- write_en  out  1  write-driver phase strobe.

Behaviour:
- Handshake occurs when req_valid && req_ready at a posedge.
  - Address, we, wdata and inj_perr are captured in internal registers.
  - Inputs are ignored at all other times. Single outstanding request; no backpressure on rsp.
- States: INIT, IDLE, PRE, WL, SENSE, WRITE.
- Reset:
  - While rst=1: state=INIT, sweep counter=0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_perr, pre_en, wl_en, wl_addr, sense_en, write_en.
- INIT (after rst falls):
  - Each cycle: wl_en=1, write_en=1, wl_addr=counter; writes 0 (and parity 0) to that row.
  - Counter increments each cycle. After row DEPTH-1 the next state is IDLE.
  - Duration: exactly DEPTH cycles.
- IDLE: req_ready=1. On handshake the next state is PRE.
- PRE: pre_en=1 for exactly PRE_CYCLES cycles, then:
  - WL if read;
  - WRITE if write.
- WRITE (one cycle): wl_en=1, write_en=1, wl_addr=captured address. Array updates at the end of the cycle. Next state IDLE. No response is generated.
- Read phases:
  - WL (one cycle): wl_en=1, wl_addr=captured address.
  - SENSE (one cycle): wl_en=1, sense_en=1. Array word is registered into rsp_rdata at the end of the cycle. Next state IDLE.
  - rsp_valid=1 during the first IDLE cycle after SENSE.
- Latency, with handshake at cycle 0:
  - Read: rsp_valid in cycle PRE_CYCLES+3.
  - Write: req_ready returns in cycle PRE_CYCLES+2.
- Strobe rules:
  - Strobes are mutually exclusive per cycle, except wl_en with write_en or sense_en.
  - wl_addr=0 whenever wl_en=0.
- Out-of-range address (≥DEPTH): write is sequenced normally but the array is unchanged; read returns 0 with rsp_perr=0.
- Read after write to the same address returns the new data. A back-to-back request handshake is allowed in the rsp_valid cycle.
- rst mid-operation:
  - Aborts immediately; any pending read response is dropped (no rsp_valid).
  - A write not yet in its WRITE cycle is lost.
  - The INIT sweep restarts from row 0.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Each row stores an extra bit = ^wdata ^ inj_perr.
  - On read, rsp_perr = stored bit != ^(read word), registered with rsp_rdata.
  - INIT writes parity 0, which is consistent with zero data.
- Undefined:
  - No parity storage.
  - rsp_perr is tied 0 and inj_perr is ignored.
  - Ports are present in both builds.

Decomposition:
- Package sram_pkg contains:
  - state enum sram_state_t {INIT, IDLE, PRE, WL, SENSE, WRITE};
  - constant PRE_CYCLES_MIN=1.
- Sub-module sram_phase_seq holds:
  - FSM, precharge counter, INIT sweep counter, and strobe generation.
- Top level holds:
  - storage array, request capture registers, read/parity datapath.

Test Plan:
- Reset release with DEPTH=64: req_ready=0 for exactly 64 cycles (wl_addr sweeps 0..63, write_en=1), then req_ready=1; a read of addr 5 returns 0x00.
- Write 0xA5 to addr 3, then read addr 3 with PRE_CYCLES=2: pre_en high cycles 1-2, sense_en in cycle 4, rsp_valid in cycle 5 with rdata=0xA5.
- Write 0x3C to addr 7 and immediately (in the req_ready cycle) write 0xC3 to addr 7, then read: returns 0xC3; req_valid held during busy cycles is not accepted.
- DEPTH=48: write 0xFF to addr 50, then read addr 50 → 0x00; read addr 47 → 0x00; no other row altered.
- Read addr 2 issued, rst asserted during SENSE: no rsp_valid; 48/64-cycle INIT reruns; prior data reads back 0.
- SRAM_PARITY_EN: write 0x01 with inj_perr=1, then read → rsp_perr=1, rdata=0x01; rewrite with inj_perr=0 → rsp_perr=0; without the macro, rsp_perr stays 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the sequenced SRAM bank.
package sram_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PRE,
    WL,
    SENSE,
    WRITE
  } sram_state_t;

  localparam int PRE_CYCLES_MIN = 1;

endpackage

// File: rtl/sram_phase_seq.sv
// Phase sequencer for one SRAM bank: FSM, precharge timer, power-up clear sweep
// and the pre/wordline/sense/write strobes.
module sram_phase_seq
  import sram_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int PRE_CYCLES = 2,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              op_we,
  input  logic [ADDR_W-1:0] op_addr,
  output sram_state_t       state,
  output logic              req_ready,
  output logic              pre_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              sense_en,
  output logic              write_en
);

  localparam int PRE_LEN = (PRE_CYCLES < PRE_CYCLES_MIN) ? PRE_CYCLES_MIN : PRE_CYCLES;
  localparam int CNT_W   = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  sram_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  pre_cnt_reg;
  logic [ADDR_W-1:0] sweep_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      pre_cnt_reg   <= '0;
      sweep_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pre_cnt_reg   <= (state_reg == PRE && state_next == PRE) ? pre_cnt_reg + 1'b1 : '0;
      sweep_cnt_reg <= (state_reg == INIT) ? sweep_cnt_reg + 1'b1 : '0;
    end
  end

  // Strobes are masked while rst is high so the array sees nothing during reset.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    pre_en     = 1'b0;
    wl_en      = 1'b0;
    wl_addr    = '0;
    sense_en   = 1'b0;
    write_en   = 1'b0;
    if (!rst) begin
      case (state_reg)
        INIT: begin
          wl_en    = 1'b1;
          write_en = 1'b1;
          wl_addr  = sweep_cnt_reg;
          if (sweep_cnt_reg == LAST_ROW) state_next = IDLE;
        end
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_next = PRE;
        end
        PRE: begin
          pre_en = 1'b1;
          if (pre_cnt_reg == PRE_LAST) state_next = op_we ? WRITE : WL;
        end
        WL: begin
          wl_en      = 1'b1;
          wl_addr    = op_addr;
          state_next = SENSE;
        end
        SENSE: begin
          wl_en      = 1'b1;
          sense_en   = 1'b1;
          wl_addr    = op_addr;
          state_next = IDLE;
        end
        WRITE: begin
          wl_en      = 1'b1;
          write_en   = 1'b1;
          wl_addr    = op_addr;
          state_next = IDLE;
        end
        default: state_next = INIT;
      endcase
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/sram_bank_seq.sv
// DATA_W x DEPTH SRAM bank with built-in phase sequencer and fixed read latency.
// Optional per-row parity storage is enabled by defining SRAM_PARITY_EN.
module sram_bank_seq
  import sram_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 64,
  parameter  int PRE_CYCLES = 2,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              inj_perr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic              pre_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              sense_en,
  output logic              write_en
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  sram_state_t       seq_state;
  logic              handshake;
  logic              cap_we_reg;
  logic [ADDR_W-1:0] cap_addr_reg;
  logic [DATA_W-1:0] cap_wdata_reg;
  logic              in_range;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_array [DEPTH];

  sram_phase_seq #(
    .DEPTH     (DEPTH),
    .PRE_CYCLES(PRE_CYCLES),
    .ADDR_W    (ADDR_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .op_we    (cap_we_reg),
    .op_addr  (cap_addr_reg),
    .state    (seq_state),
    .req_ready(req_ready),
    .pre_en   (pre_en),
    .wl_en    (wl_en),
    .wl_addr  (wl_addr),
    .sense_en (sense_en),
    .write_en (write_en)
  );

  assign handshake = req_valid && req_ready;
  assign in_range  = ({1'b0, cap_addr_reg} < DEPTH_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we_reg    <= 1'b0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
    end else if (handshake) begin
      cap_we_reg    <= req_we;
      cap_addr_reg  <= req_addr;
      cap_wdata_reg <= req_wdata;
    end
  end

  // Single write port: the INIT sweep clears rows, WRITE stores captured data.
  // wl_addr always carries the target row while write_en is high.
  assign wr_en   = write_en && (seq_state == INIT || in_range);
  assign wr_data = (seq_state == INIT) ? '0 : cap_wdata_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem_array[wl_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= sense_en;
      if (sense_en) rsp_rdata_reg <= in_range ? mem_array[cap_addr_reg] : '0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

`ifdef SRAM_PARITY_EN
  logic cap_perr_reg;
  logic rsp_perr_reg;
  logic wr_par;
  logic par_array [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) cap_perr_reg <= 1'b0;
    else if (handshake) cap_perr_reg <= inj_perr;
  end

  assign wr_par = (seq_state == INIT) ? 1'b0 : ((^cap_wdata_reg) ^ cap_perr_reg);

  always_ff @(posedge clk) begin
    if (wr_en) par_array[wl_addr] <= wr_par;
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_perr_reg <= 1'b0;
    else if (sense_en)
      rsp_perr_reg <= in_range ? (par_array[cap_addr_reg] ^ (^mem_array[cap_addr_reg])) : 1'b0;
  end

  assign rsp_perr = rsp_perr_reg;
`else
  logic unused_inj_perr;
  assign unused_inj_perr = inj_perr;
  assign rsp_perr        = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank_seq.sv
// Scoreboard bench for sram_bank_seq: directed phase/latency checks plus random
// traffic against an array-based reference model.
module tb_sram_bank_seq;
  import sram_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 48;
  localparam int PRE    = 2;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef SRAM_PARITY_EN
  localparam bit PERR_ON = 1'b1;
`else
  localparam bit PERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              inj_perr = 1'b0;
  logic              req_ready, rsp_valid, rsp_perr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              pre_en, wl_en, sense_en, write_en;
  logic [ADDR_W-1:0] wl_addr;

  always #5 clk = ~clk;

  sram_bank_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_CYCLES(PRE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inj_perr(inj_perr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .pre_en(pre_en), .wl_en(wl_en), .wl_addr(wl_addr),
    .sense_en(sense_en), .write_en(write_en)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   rsp_count = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_bad [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Monitor: strobe legality every cycle, and response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      check("strobe_rules",
            {(pre_en && (wl_en || sense_en || write_en)), (sense_en && write_en),
             ((sense_en || write_en) && !wl_en), (!wl_en && wl_addr != '0)}, 4'b0000);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid with rdata=0x%0h, expected no response",
                   rsp_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          rsp_count++;
          $display("rsp %0d: rdata=0x%02h perr=%0b (expected 0x%02h/%0b)",
                   rsp_count, rsp_rdata, rsp_perr, mon_e.data, mon_e.perr);
          check("rsp_rdata", rsp_rdata, mon_e.data);
          check("rsp_perr", rsp_perr, mon_e.perr);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, expected finish before 5ms");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
  endtask

  // Drives garbage with valid high while the bank is busy, then the real request.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic inj);
    exp_t e;
    int   waited = 0;
    bit   done = 0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        inj_perr  = inj;
        @(posedge clk);
        done = 1;
        if (we) begin
          if (int'(addr) < DEPTH) begin
            ref_mem[addr] = wdata;
            ref_bad[addr] = inj;
          end
        end else begin
          e.data = (int'(addr) < DEPTH) ? ref_mem[addr] : '0;
          e.perr = (int'(addr) < DEPTH) ? (PERR_ON && ref_bad[addr]) : 1'b0;
          exp_q.push_back(e);
        end
        $display("req %s addr=%0d wdata=0x%02h inj=%0b", we ? "WR" : "RD", addr, wdata, inj);
        #1 req_valid = 1'b0;
      end else begin
        req_valid = 1'b1;
        req_we    = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = DATA_W'($urandom);
        inj_perr  = 1'($urandom);
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("FAIL req_timeout: got req_ready=0 for %0d cycles, expected ready", waited);
          req_valid = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  // Cycle-by-cycle strobe pattern after a handshake (cycle 0).
  task automatic check_phases(input logic we, input logic [ADDR_W-1:0] addr);
    int last = we ? PRE + 2 : PRE + 3;
    logic rdy, rv, pre, wl, sen, wr;
    logic [ADDR_W-1:0] wla;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      rdy = (c == last);
      rv  = !we && (c == PRE + 3);
      pre = (c <= PRE);
      wl  = (c == PRE + 1) || (!we && c == PRE + 2);
      sen = !we && (c == PRE + 2);
      wr  = we && (c == PRE + 1);
      wla = wl ? addr : '0;
      check($sformatf("phase_%s_c%0d", we ? "wr" : "rd", c),
            {req_ready, rsp_valid, pre_en, wl_en, sense_en, write_en, wl_addr},
            {rdy, rv, pre, wl, sen, wr, wla});
    end
  endtask

  // Caller leaves rst high (or it is raised here); release then verify the sweep.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, rsp_perr, pre_en, wl_en, wl_addr, sense_en, write_en},
          '0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check($sformatf("init_row%0d", k), {req_ready, wl_en, write_en, wl_addr},
            {1'b0, 1'b1, 1'b1, ADDR_W'(k)});
    end
    @(negedge clk);
    check("ready_after_init", req_ready, 1'b1);
  endtask

  initial begin
    int waited;
    model_clear();
    do_reset();

    do_req(1'b0, ADDR_W'(5), '0, 1'b0);

    do_req(1'b1, ADDR_W'(3), 8'hA5, 1'b0);
    check_phases(1'b1, ADDR_W'(3));
    do_req(1'b0, ADDR_W'(3), '0, 1'b0);
    check_phases(1'b0, ADDR_W'(3));

    do_req(1'b1, ADDR_W'(7), 8'h3C, 1'b0);
    do_req(1'b1, ADDR_W'(7), 8'hC3, 1'b0);
    do_req(1'b0, ADDR_W'(7), '0, 1'b0);

    do_req(1'b1, ADDR_W'(50), 8'hFF, 1'b0);
    do_req(1'b0, ADDR_W'(50), '0, 1'b0);
    do_req(1'b0, ADDR_W'(47), '0, 1'b0);

    do_req(1'b1, ADDR_W'(9), 8'h01, 1'b1);
    do_req(1'b0, ADDR_W'(9), '0, 1'b0);
    do_req(1'b1, ADDR_W'(9), 8'h01, 1'b0);
    do_req(1'b0, ADDR_W'(9), '0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)),
             DATA_W'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, ADDR_W'(a), '0, 1'b0);

    // Abort a read in its SENSE cycle: no response, sweep reruns, data cleared.
    do_req(1'b1, ADDR_W'(2), 8'h5A, 1'b0);
    do_req(1'b0, ADDR_W'(2), '0, 1'b0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!sense_en && waited < 20);
    check("sense_seen_before_abort", sense_en, 1'b1);
    do_reset();
    do_req(1'b0, ADDR_W'(2), '0, 1'b0);
    do_req(1'b0, ADDR_W'(3), '0, 1'b0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("responses_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
